memory_2p: RTL and testbench

Parametrised simple-dual-port synchronous RAM: one write port and one read port, both on the same clock. It is the next-generation replacement for the single-port word memory. It adds per-lane write masking and a selectable read-during-write policy. A hardware initialisation sequencer fills every word after reset or on request. Used as program/data storage for the datapath; clients must wait for `busy` low before relying on contents.

---
 rtl/memory_2p.sv | 153 +++++++++++++++
 tb/tb_memory_2p.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/memory_2p.sv
// memory_2p: simple-dual-port synchronous RAM with per-lane write masking,
// selectable read-during-write behaviour and a hardware fill sequencer that
// initialises every word after reset or on a clear request.
module memory_2p #(
  parameter int ADDRWIDTH = 12,
  parameter int DATAWIDTH = 16,
  parameter int WORDS     = 4096,
  parameter int LANEWIDTH = 8,
  parameter int INIT_MODE = 1,
  parameter int RDW_MODE  = 0,
  localparam int NLANES   = DATAWIDTH / LANEWIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  output logic                 busy,
  input  logic                 we,
  input  logic [ADDRWIDTH-1:0] waddr,
  input  logic [DATAWIDTH-1:0] wdata,
  input  logic [NLANES-1:0]    wmask,
  input  logic                 re,
  input  logic [ADDRWIDTH-1:0] raddr,
  output logic [DATAWIDTH-1:0] rdata,
  output logic                 rvalid
);

  // Index width just large enough to address WORDS entries.
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

  typedef enum logic {INIT, READY} state_e;

  state_e                 state_q, state_d;
  logic [IW-1:0]          cnt_q, cnt_d;
  logic [DATAWIDTH-1:0]   rdata_q, rdata_d;
  logic                   rvalid_q, rvalid_d;

  logic [DATAWIDTH-1:0]   mem [0:WORDS-1];

  // Single physical write port shared by the fill sequencer and the client.
  logic                   mem_we;
  logic [IW-1:0]          mem_waddr;
  logic [DATAWIDTH-1:0]   mem_wdata;
  logic [NLANES-1:0]      mem_wmask;

  logic                   wr_in_range;
  logic                   rd_in_range;
  logic [DATAWIDTH-1:0]   rd_word;

  // Fill value for word idx: its own index (zero-extended/truncated) or zero.
  function automatic logic [DATAWIDTH-1:0] fill_word(input logic [IW-1:0] idx);
    if (INIT_MODE == 1) return DATAWIDTH'(idx);
    else                return '0;
  endfunction

  // Word as it looks after a masked write: selected lanes new, others old.
  function automatic logic [DATAWIDTH-1:0] merge_word(
    input logic [DATAWIDTH-1:0] old_w,
    input logic [DATAWIDTH-1:0] new_w,
    input logic [NLANES-1:0]    mask
  );
    logic [DATAWIDTH-1:0] res;
    res = old_w;
    for (int k = 0; k < NLANES; k++) begin
      if (mask[k]) res[k*LANEWIDTH +: LANEWIDTH] = new_w[k*LANEWIDTH +: LANEWIDTH];
    end
    return res;
  endfunction

  assign wr_in_range = (32'(waddr) < 32'(WORDS));
  assign rd_in_range = (32'(raddr) < 32'(WORDS));

  // Next-state, fill/write port selection and read-data computation.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    rvalid_d  = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = cnt_q;
    mem_wdata = fill_word(cnt_q);
    mem_wmask = '1;
    rd_word   = '0;
    case (state_q)
      INIT: begin
        mem_we = 1'b1;
        if (clear) begin
          cnt_d = '0;
        end else if (cnt_q == LAST_IDX) begin
          cnt_d   = '0;
          state_d = READY;
        end else begin
          cnt_d = cnt_q + IW'(1);
        end
      end
      READY: begin
        if (we && wr_in_range) begin
          mem_we    = 1'b1;
          mem_waddr = waddr[IW-1:0];
          mem_wdata = wdata;
          mem_wmask = wmask;
        end
        if (re) begin
          rvalid_d = 1'b1;
          if (rd_in_range) begin
            rd_word = mem[raddr[IW-1:0]];
            // Write-first: a colliding write is forwarded into the read result.
            if ((RDW_MODE == 1) && we && wr_in_range && (waddr == raddr)) begin
              rd_word = merge_word(rd_word, wdata, wmask);
            end
          end
          rdata_d = rd_word;
        end
        if (clear) begin
          state_d = INIT;
          cnt_d   = '0;
        end
      end
      default: state_d = INIT;
    endcase
  end

  // Control and read-output registers; reset restarts the fill sequence.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= INIT;
      cnt_q    <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  // Storage array with lane-granular write enables; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int k = 0; k < NLANES; k++) begin
        if (mem_wmask[k]) begin
          mem[mem_waddr][k*LANEWIDTH +: LANEWIDTH] <= mem_wdata[k*LANEWIDTH +: LANEWIDTH];
        end
      end
    end
  end

  assign busy   = (state_q == INIT);
  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;

endmodule

// File: tb/tb_memory_2p.sv
// Scoreboard bench for memory_2p: three parameter sets run side by side, each
// with its own stimulus process, reference model and output monitor.
module tb_memory_2p;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h at %0t", nm, act, exp, $time);
    end
  endfunction

  for (genvar G = 0; G < 3; G++) begin : g_cfg
    localparam int AW    = (G == 2) ? 5 : 4;
    localparam int WORDS = (G == 0) ? 16 : (G == 1) ? 12 : 20;
    localparam int LW    = (G == 2) ? 4 : 8;
    localparam int NL    = 16 / LW;
    localparam int INITM = (G == 2) ? 0 : 1;
    localparam int RDW   = (G == 1) ? 1 : 0;
    localparam int FULL  = (1 << NL) - 1;
    localparam int LO    = (1 << (NL / 2)) - 1;
    localparam int HI    = FULL ^ LO;

    logic          rst_n = 1'b0;
    logic          clear = 1'b0;
    logic          we = 1'b0;
    logic          re = 1'b0;
    logic [AW-1:0] waddr = '0;
    logic [AW-1:0] raddr = '0;
    logic [15:0]   wdata = '0;
    logic [NL-1:0] wmask = '0;
    logic [15:0]   rdata;
    logic          rvalid;
    logic          busy;

    memory_2p #(
      .ADDRWIDTH(AW), .DATAWIDTH(16), .WORDS(WORDS), .LANEWIDTH(LW),
      .INIT_MODE(INITM), .RDW_MODE(RDW)
    ) dut (
      .clk(clk), .rst_n(rst_n), .clear(clear), .busy(busy),
      .we(we), .waddr(waddr), .wdata(wdata), .wmask(wmask),
      .re(re), .raddr(raddr), .rdata(rdata), .rvalid(rvalid)
    );

    // Reference model: memory contents, remaining init cycles, expectations.
    logic [15:0] mm [WORDS];
    int          left;
    logic [15:0] rq [$];
    bit          bq [$];
    logic [15:0] last;
    bit          done = 1'b0;

    function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] nw, input int m);
      logic [15:0] r;
      r = old;
      for (int b = 0; b < 16; b++) if (m[b / LW]) r[b] = nw[b];
      return r;
    endfunction

    function automatic void refill();
      for (int i = 0; i < WORDS; i++) mm[i] = (INITM == 1) ? 16'(i) : 16'h0;
    endfunction

    // One clock of stimulus; model outcome is queued for the monitor.
    task automatic cyc(input bit w, input int wa, input logic [15:0] wd, input int wm,
                       input bit r, input int ra, input bit c);
      logic [15:0] e;
      we = w; waddr = wa[AW-1:0]; wdata = wd; wmask = wm[NL-1:0];
      re = r; raddr = ra[AW-1:0]; clear = c;
      if (left > 0) begin
        left = c ? WORDS : left - 1;
      end else begin
        if (r) begin
          if (ra >= WORDS) e = 16'h0;
          else begin
            e = mm[ra];
            if (RDW == 1 && w && wa == ra) e = merge(e, wd, wm);
          end
          rq.push_back(e);
        end
        if (w && wa < WORDS) mm[wa] = merge(mm[wa], wd, wm);
        if (c) begin
          left = WORDS;
          refill();
        end
      end
      bq.push_back(left > 0);
      @(negedge clk);
    endtask

    task automatic idle(input int n);
      repeat (n) cyc(0, 0, 16'h0, 0, 0, 0, 0);
    endtask

    task automatic rd(input int a);
      cyc(0, 0, 16'h0, 0, 1, a, 0);
    endtask

    task automatic wr(input int a, input logic [15:0] d, input int m);
      cyc(1, a, d, m, 0, 0, 0);
    endtask

    task automatic do_reset();
      rst_n = 1'b0;
      we = 0; re = 0; clear = 0;
      rq.delete();
      bq.delete();
      #1;
      chk($sformatf("c%0d reset_busy", G), 32'(busy), 32'd1);
      chk($sformatf("c%0d reset_rvalid", G), 32'(rvalid), 32'd0);
      chk($sformatf("c%0d reset_rdata", G), 32'(rdata), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      left = WORDS;
      refill();
      last = 16'h0;
    endtask

    // Monitor: compares busy every cycle and pops a read result on rvalid.
    always @(posedge clk) begin
      #1;
      if (!done && rst_n) begin
        if (bq.size() == 0) begin
          chk($sformatf("c%0d sb_underflow", G), 32'd1, 32'd0);
        end else begin
          chk($sformatf("c%0d busy", G), 32'(busy), 32'(bq.pop_front()));
        end
        if (rq.size() > 0) begin
          logic [15:0] e;
          e = rq.pop_front();
          chk($sformatf("c%0d rvalid", G), 32'(rvalid), 32'd1);
          if (rvalid) chk($sformatf("c%0d rdata", G), 32'(rdata), 32'(e));
          last = e;
        end else begin
          chk($sformatf("c%0d rvalid_idle", G), 32'(rvalid), 32'd0);
          if (!rvalid) chk($sformatf("c%0d rdata_hold", G), 32'(rdata), 32'(last));
        end
      end
    end

    initial begin
      @(negedge clk);
      do_reset();
      idle(WORDS);
      rd(5); rd(0); rd(WORDS - 1);
      // Masked writes: low lanes, then high lanes, then empty mask.
      wr(3, 16'hABCD, LO); rd(3);
      wr(3, 16'hABCD, HI); rd(3);
      wr(3, 16'h5555, 0);  rd(3);
      // Same-address read during write, full and partial masks.
      cyc(1, 7, 16'h1234, FULL, 1, 7, 0); rd(7);
      cyc(1, 7, 16'hBEEF, LO, 1, 7, 0);   rd(7);
      // Different-address read and write in one cycle.
      cyc(1, 8, 16'h4321, FULL, 1, 9, 0); rd(8);
      // Out-of-range write is dropped; out-of-range read returns zero.
      if (WORDS < (1 << AW)) begin
        wr(WORDS + 1, 16'hDEAD, FULL);
        for (int a = 0; a < (1 << AW); a++) rd(a);
      end
      // Clear: writes and reads during init are ignored, contents refilled.
      wr(2, 16'hFFFF, FULL);
      cyc(0, 0, 16'h0, 0, 0, 0, 1);
      cyc(0, 0, 16'h0, 0, 0, 0, 1);
      rd(4);
      cyc(1, 2, 16'h7777, FULL, 1, 2, 0);
      idle(WORDS);
      rd(2); rd(3);
      // Reset in the middle of an init sequence.
      cyc(0, 0, 16'h0, 0, 0, 0, 1);
      idle(8);
      do_reset();
      idle(WORDS);
      rd(2); rd(7);
      // Randomised traffic with occasional clears.
      for (int i = 0; i < 400; i++) begin
        int wa, ra;
        wa = $urandom_range(0, (1 << AW) - 1);
        ra = ($urandom_range(0, 3) == 0) ? wa : $urandom_range(0, (1 << AW) - 1);
        cyc(bit'($urandom_range(0, 1)), wa, 16'($urandom), $urandom_range(0, FULL),
            bit'($urandom_range(0, 1)), ra, bit'($urandom_range(0, 79) == 0));
      end
      idle(WORDS);
      // Reset during normal operation clears the read outputs.
      wr(1, 16'hC3C3, FULL);
      rd(1);
      do_reset();
      idle(WORDS);
      rd(1); rd(WORDS - 1);
      idle(2);
      done = 1'b1;
    end
  end

  initial begin
    int n;
    n = 0;
    while (!(g_cfg[0].done && g_cfg[1].done && g_cfg[2].done) && n < 20000) begin
      @(posedge clk);
      n++;
    end
    if (n >= 20000) begin
      checks++;
      errors++;
      $display("FAIL timeout cycles=%0d limit=%0d", n, 20000);
    end
    #20;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
